// File: rtl/hue_anim_gen_pkg.sv
// Shared encodings for the animated hue source: sweep modes, burst FSM states
// and the half-turn hue offset used by the hit flash.
package hue_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'd0,
    MODE_UP       = 2'd1,
    MODE_DOWN     = 2'd2,
    MODE_PINGPONG = 2'd3
  } hue_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } hue_state_e;

  localparam logic [7:0] HUE_HALF = 8'd128;

endpackage

// File: rtl/hue_anim_gen_if.sv
// Pixel request/response bundle between the raster scanner and the hue source.
// Handshake: pix_valid qualifies pixel_x/x_spread in the cycle it is high; there is
// no ready (the source always accepts), and hue_valid is pix_valid delayed by one clock
// with hue carrying the result for that request in the same cycle as hue_valid.
interface hue_anim_gen_if #(
    parameter int X_W = 7
);
    logic           pix_valid;
    logic [X_W-1:0] pixel_x;
    logic [2:0]     x_spread;
    logic [7:0]     hue;
    logic           hue_valid;

    modport master (
        output pix_valid,
        output pixel_x,
        output x_spread,
        input  hue,
        input  hue_valid
    );

    modport slave (
        input  pix_valid,
        input  pixel_x,
        input  x_spread,
        output hue,
        output hue_valid
    );
endinterface

// File: rtl/hue_anim_gen_step_unit.sv
// Combinational next-base / next-direction for one animation step, including the
// saturating ping-pong bounce at 0 and 255.
module hue_step_unit
    import hue_pkg::*;
(
    input  logic [7:0] base,
    input  logic       dir_down,
    input  logic [1:0] mode,
    input  logic [7:0] step_size,
    output logic [7:0] next_base,
    output logic       next_dir_down
);

    logic [8:0] sum9;

    always_comb begin
        next_base     = base;
        next_dir_down = dir_down;
        sum9          = {1'b0, base} + {1'b0, step_size};
        case (mode)
            MODE_UP:   next_base = base + step_size;
            MODE_DOWN: next_base = base - step_size;
            MODE_PINGPONG: begin
                // A zero step must not bounce off an endpoint it is already sitting on.
                if (step_size != 8'd0) begin
                    if (!dir_down) begin
                        if (sum9 >= 9'd255) begin
                            next_base     = 8'd255;
                            next_dir_down = 1'b1;
                        end else begin
                            next_base = sum9[7:0];
                        end
                    end else begin
                        if (base <= step_size) begin
                            next_base     = 8'd0;
                            next_dir_down = 1'b0;
                        end else begin
                            next_base = base - step_size;
                        end
                    end
                end
            end
            default: next_base = base;
        endcase
    end

endmodule

// File: rtl/hue_anim_gen.sv
// Animated hue source: per-frame base hue (hold/sweep/ping-pong) with a hit-flash
// burst, plus a registered per-pixel rainbow offset.
module hue_anim_gen
    import hue_pkg::*;
#(
    parameter int X_W     = 7,
    parameter int DIV_W   = 4,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [DIV_W-1:0]   speed_div,
    input  logic [7:0]         step_size,
    input  logic               burst_start,
    input  logic [BURST_W-1:0] burst_len,
    hue_anim_gen_if.slave      pix,
    output logic [7:0]         base_hue,
    output logic               busy,
    output hue_state_e         state_dbg
);

    hue_state_e         state_q;
    logic [7:0]         base_q;
    logic [7:0]         saved_q;
    logic               dir_down_q;
    logic [DIV_W-1:0]   frame_cnt_q;
    logic [BURST_W-1:0] remaining_q;

    logic [7:0]         step_base;
    logic               step_dir_down;
    logic               burst_go;
    logic [X_W+6:0]     x_offset;

    hue_step_unit u_step (
        .base          (base_q),
        .dir_down      (dir_down_q),
        .mode          (mode),
        .step_size     (step_size),
        .next_base     (step_base),
        .next_dir_down (step_dir_down)
    );

    assign burst_go  = burst_start && (burst_len != '0);
    assign x_offset  = {7'd0, pix.pixel_x} << pix.x_spread;
    assign base_hue  = base_q;
    assign state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            base_q      <= 8'd0;
            saved_q     <= 8'd0;
            dir_down_q  <= 1'b0;
            frame_cnt_q <= '0;
            remaining_q <= '0;
            busy        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A burst request wins over a coincident frame tick; that step is dropped.
                    if (burst_go) begin
                        saved_q     <= base_q;
                        remaining_q <= burst_len;
                        state_q     <= ST_BURST;
                        busy        <= 1'b1;
                    end else if (frame_tick && en) begin
                        if (frame_cnt_q == speed_div) begin
                            frame_cnt_q <= '0;
                            base_q      <= step_base;
                            dir_down_q  <= step_dir_down;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                    end
                end
                ST_BURST: begin
                    // burst_len ticks show the flash pattern; the following tick restores.
                    if (frame_tick) begin
                        if (remaining_q == '0) begin
                            base_q  <= saved_q;
                            state_q <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            base_q      <= base_q + HUE_HALF;
                            remaining_q <= remaining_q - 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix.hue       <= 8'd0;
            pix.hue_valid <= 1'b0;
        end else begin
            pix.hue       <= base_q + x_offset[7:0];
            pix.hue_valid <= pix.pix_valid;
        end
    end

endmodule

// File: tb/tb_hue_anim_gen.sv
// Directed bench for hue_anim_gen: sweep, ping-pong, flash burst, pixel path and reset.
module tb_hue_anim_gen;
    import hue_pkg::*;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       en;
    logic [1:0] mode;
    logic [3:0] speed_div;
    logic [7:0] step_size;
    logic       burst_start;
    logic [7:0] burst_len;
    logic [7:0] base_hue;
    logic       busy;
    hue_state_e state_dbg;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    hue_anim_gen_if #(.X_W(7)) pix ();

    hue_anim_gen #(.X_W(7), .DIV_W(4), .BURST_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .en          (en),
        .mode        (mode),
        .speed_div   (speed_div),
        .step_size   (step_size),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .pix         (pix.slave),
        .base_hue    (base_hue),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    function automatic logic [7:0] model_hue(input logic [7:0] b, input logic [6:0] x, input logic [2:0] s);
        logic [13:0] wide;
        wide = {7'd0, x} << s;
        return b + wide[7:0];
    endfunction

    task automatic send_pixel(input logic [7:0] b, input logic [6:0] x, input logic [2:0] s);
        pix.pix_valid = 1'b1;
        pix.pixel_x   = x;
        pix.x_spread  = s;
        exp_q.push_back(model_hue(b, x, s));
        cyc();
        pix.pix_valid = 1'b0;
        pix.pixel_x   = 7'd0;
        pix.x_spread  = 3'd0;
        chk("hue_valid_pulse", {31'd0, pix.hue_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            chk("pixel_hue", {24'd0, pix.hue}, {24'd0, exp_q.pop_front()});
        end
    endtask

    initial begin
        logic [7:0] pp_vals[7];
        logic [7:0] prev;
        pp_vals = '{8'd100, 8'd200, 8'd255, 8'd155, 8'd55, 8'd0, 8'd100};

        reset = 1'b1; frame_tick = 1'b0; en = 1'b0; mode = 2'd0;
        speed_div = 4'd0; step_size = 8'd0; burst_start = 1'b0; burst_len = 8'd0;
        pix.pix_valid = 1'b0; pix.pixel_x = 7'd0; pix.x_spread = 3'd0;
        cyc(); cyc();
        chk("rst_base", {24'd0, base_hue}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hue", {24'd0, pix.hue}, 32'd0);
        chk("rst_hue_valid", {31'd0, pix.hue_valid}, 32'd0);
        chk("rst_state", {31'd0, state_dbg}, {31'd0, ST_IDLE});
        reset = 1'b0;

        // Sweep up by 10 every tick, wrapping after 250.
        mode = 2'd1; step_size = 8'd10; speed_div = 4'd0; en = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            frame();
            chk("sweep_up", {24'd0, base_hue}, (i * 10) % 256);
        end

        // Sweep down by 10: 44 -> 34.
        mode = 2'd2;
        frame();
        chk("sweep_down", {24'd0, base_hue}, 32'd34);

        // Ping-pong, step every second tick.
        do_reset();
        mode = 2'd3; step_size = 8'd100; speed_div = 4'd1;
        prev = 8'd0;
        for (int i = 0; i < 7; i++) begin
            frame();
            chk("pp_hold_tick", {24'd0, base_hue}, {24'd0, prev});
            frame();
            chk("pp_step", {24'd0, base_hue}, {24'd0, pp_vals[i]});
            prev = pp_vals[i];
        end

        // Flash burst from base 40.
        do_reset();
        mode = 2'd1; step_size = 8'd40; speed_div = 4'd0;
        frame();
        chk("burst_pre_base", {24'd0, base_hue}, 32'd40);
        mode = 2'd0;
        burst_start = 1'b1; burst_len = 8'd3;
        cyc();
        burst_start = 1'b0;
        chk("burst_busy_on", {31'd0, busy}, 32'd1);
        chk("burst_state", {31'd0, state_dbg}, {31'd0, ST_BURST});
        chk("burst_base_hold", {24'd0, base_hue}, 32'd40);
        frame();
        chk("burst_t1", {24'd0, base_hue}, 32'd168);
        burst_start = 1'b1; burst_len = 8'd9;
        cyc();
        burst_start = 1'b0;
        frame();
        chk("burst_t2", {24'd0, base_hue}, 32'd40);
        frame();
        chk("burst_t3", {24'd0, base_hue}, 32'd168);
        chk("burst_busy_t3", {31'd0, busy}, 32'd1);
        frame();
        chk("burst_restore", {24'd0, base_hue}, 32'd40);
        chk("burst_busy_off", {31'd0, busy}, 32'd0);
        chk("burst_idle", {31'd0, state_dbg}, {31'd0, ST_IDLE});

        // Burst start coinciding with a tick: the step is dropped.
        mode = 2'd1;
        burst_start = 1'b1; burst_len = 8'd1; frame_tick = 1'b1;
        cyc();
        burst_start = 1'b0; frame_tick = 1'b0;
        chk("coinc_base", {24'd0, base_hue}, 32'd40);
        chk("coinc_busy", {31'd0, busy}, 32'd1);
        frame();
        chk("coinc_t1", {24'd0, base_hue}, 32'd168);
        frame();
        chk("coinc_restore", {24'd0, base_hue}, 32'd40);
        frame();
        chk("post_burst_step", {24'd0, base_hue}, 32'd80);

        // Pixel path from base 200.
        do_reset();
        mode = 2'd1; step_size = 8'd200;
        frame();
        chk("pix_pre_base", {24'd0, base_hue}, 32'd200);
        mode = 2'd0;
        send_pixel(8'd200, 7'd95, 3'd1);
        cyc();
        chk("hue_valid_drop", {31'd0, pix.hue_valid}, 32'd0);
        send_pixel(8'd200, 7'd3, 3'd7);
        send_pixel(8'd200, 7'd0, 3'd0);

        // Enable low freezes stepping; zero-length burst is ignored.
        mode = 2'd1; en = 1'b0; step_size = 8'd7;
        for (int i = 0; i < 5; i++) frame();
        chk("en_freeze", {24'd0, base_hue}, 32'd200);
        burst_start = 1'b1; burst_len = 8'd0;
        cyc();
        burst_start = 1'b0;
        chk("zero_len_busy", {31'd0, busy}, 32'd0);
        chk("zero_len_state", {31'd0, state_dbg}, {31'd0, ST_IDLE});

        // Reset in the middle of a burst.
        burst_start = 1'b1; burst_len = 8'd4;
        cyc();
        burst_start = 1'b0;
        frame();
        chk("mid_burst_base", {24'd0, base_hue}, 32'd72);
        reset = 1'b1;
        cyc();
        chk("mid_rst_base", {24'd0, base_hue}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_hue", {24'd0, pix.hue}, 32'd0);
        chk("mid_rst_state", {31'd0, state_dbg}, {31'd0, ST_IDLE});
        reset = 1'b0;
        en = 1'b1; step_size = 8'd10;
        frame();
        chk("post_rst_sweep", {24'd0, base_hue}, 32'd10);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hue_anim_gen.md
Name: hue_anim_gen

Overview:
- Animated hue source that feeds the HSV-to-RGB565 converter's 8-bit hue input.
- Keeps a per-frame base hue that evolves by mode: hold, sweep up, sweep down or ping-pong. Supports a hit-flash burst that toggles the hue by 180°.
- Per pixel, adds an x-dependent offset to produce rainbow gradients across the 96-wide OLED. The result is registered with a 1-cycle valid pipeline.

Parameters:
- X_W, 7, pixel_x width (96-column display)
- DIV_W, 4, width of speed_div (frames per step minus 1)
- BURST_W, 8, width of burst_len / burst frame counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse, once per display frame
- en  in  1  animation enable (gates base stepping only)
- mode  in  2  0 hold, 1 sweep up, 2 sweep down, 3 ping-pong
- speed_div  in  DIV_W  step occurs every speed_div+1 frame ticks
- step_size  in  8  hue increment per step
- burst_start  in  1  one-cycle pulse requesting a flash burst
- burst_len  in  BURST_W  number of frame ticks the burst lasts
- pix_valid  in  1  pixel request strobe
- pixel_x  in  X_W  pixel column
- x_spread  in  3  gradient shift: offset = pixel_x << x_spread
- hue  out  8  hue for the requested pixel
- hue_valid  out  1  pix_valid delayed 1 cycle
- base_hue  out  8  current base hue (post-burst modification)
- busy  out  1  high while a burst is active

Behaviour:
- Reset values:
  - base register 0, dir up, frame_cnt 0, FSM IDLE, saved 0, remaining 0.
  - Outputs: hue 0, hue_valid 0, base_hue 0, busy 0.
- Step qualification (IDLE only):
  - On frame_tick with en=1: if frame_cnt == speed_div, fire a step and clear frame_cnt; otherwise frame_cnt+1.
  - speed_div=0 means every tick.
  - en=0 freezes frame_cnt and base. In BURST, frame_cnt is held.
- Step actions, using 8-bit modular arithmetic unless stated:
  - mode 0: no change.
  - mode 1: base += step_size, wraps 255→0.
  - mode 2: base −= step_size, wraps 0→255.
  - mode 3 ping-pong, saturating:
    - dir up: if base + step_size ≥ 255 (9-bit compare), set base=255 and dir=down; else add.
    - dir down: if base ≤ step_size, set base=0 and dir=up; else subtract.
  - step_size=0 leaves base unchanged in all modes; ping-pong dir is unchanged.
- Mode and dir rules:
  - A mode change takes effect on the next step.
  - dir persists across mode changes and is only cleared by reset.
- Burst FSM, states IDLE and BURST:
  - IDLE + burst_start + burst_len≠0: saved←base, remaining←burst_len, enter BURST. busy=1 from the next cycle.
  - burst_len=0: ignored.
  - BURST, each frame_tick: base toggles between saved and saved+128 (first tick → saved+128), and remaining −1.
  - When remaining reaches 0 on a tick: base←saved, go to IDLE, busy=0 the next cycle.
  - burst_start during BURST is ignored.
  - Burst runs regardless of en and mode.
  - frame_tick coinciding with burst_start in IDLE: the burst starts and the step is discarded; frame_cnt is unchanged.
- base_hue is driven directly from the base register.
- Pixel path, latency 1:
  - On every clk: hue ← base + (pixel_x << x_spread)[7:0], and hue_valid ← pix_valid.
  - hue updates even when pix_valid=0.
  - The base used is the register value in the same cycle as pix_valid.
- Reset mid-burst: everything returns to reset values; the saved hue is lost.

Decomposition:
- Shared package hue_pkg:
  - mode encodings (MODE_HOLD, MODE_UP, MODE_DOWN, MODE_PINGPONG)
  - FSM state encoding
  - HUE_HALF = 128
- One natural sub-module, hue_step_unit: combinational next-base and next-dir from base, dir, mode and step_size, including the saturation compare. The top level holds counters, the FSM and the pixel register.

Test Plan:
- Reset then mode=1, step_size=10, speed_div=0, en=1, 30 frame_ticks → base_hue 0,10,…,250, then 4 (wrap).
- mode=3, step_size=100, speed_div=1 → base changes every 2nd tick: 100, 200, 255(dir down), 155, 55, 0(dir up), 100.
- base=40, burst_start with burst_len=3, three ticks → base 168, 40, 168, then restored 40; busy high for exactly that span. A second burst_start mid-burst has no effect.
- base=200, pix_valid with pixel_x=95, x_spread=1 → next cycle hue=(200+190) mod 256=134, hue_valid=1. Next cycle hue_valid=0.
- en=0 with 5 frame_ticks in mode 1 → base unchanged. burst_len=0 start → busy stays 0.
- Reset asserted mid-burst → next cycle all outputs 0, FSM IDLE, and a subsequent sweep starts from 0.
